debug_rom_table_apb: RTL and testbench
======================================

DEBUG_ROM_TABLE_APB -- requirements
Module: debug_rom_table_apb

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 7: number of component entries, range 1..64.
REQ-002 SHALL have parameter RD_WAIT, default 1: extra access-phase wait cycles per read, range 0..15.
REQ-003 SHALL have parameter PWR_TIMEOUT, default 256: maximum cycles to wait for power-up, range 1..65535.
REQ-004 SHALL have parameters PART_NUM (12b, default 12'h004), JEP106_ID (7b, default 0), JEP106_CONT (4b, default 0) and REVISION (4b, default 0).
REQ-005 SHALL have port clk_i, input, 1: the only clock.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have APB inputs psel_i (1), penable_i (1), pwrite_i (1) and paddr_i (12): byte address within the 4KB table.
REQ-008 SHALL have APB outputs prdata_o (32), pready_o (1) and pslverr_o (1).
REQ-009 SHALL have port entry_base_i, input, NUM_ENTRIES*20: per-entry component base address [31:12]; entry i occupies slice [20i+19:20i].
REQ-010 SHALL have port pd_on_i, input, NUM_ENTRIES: per-entry power-domain status and acknowledge.
REQ-011 SHALL have port pwrreq_o, output, NUM_ENTRIES: per-entry power-up request.

Function
REQ-012 Read map: word index k < NUM_ENTRIES (offset 4k) SHALL return the entry {base[31:12], 10'b0, 1'b1 (32-bit format), present}.
REQ-013 Offsets from 4*NUM_ENTRIES to 0xFCC SHALL read 0 with pslverr_o=0; this covers the end marker and reserved space.
REQ-014 ID registers: 0xFD0 PID4={4'h0,JEP106_CONT}; 0xFD4..0xFDC PID5..7=0; 0xFE0 PID0=PART_NUM[7:0]; 0xFE4 PID1={JEP106_ID[3:0],PART_NUM[11:8]}; 0xFE8 PID2={REVISION,1'b1,JEP106_ID[6:4]}; 0xFEC PID3=0; 0xFF0..0xFFC CID0..3=0x0D,0x10,0x05,0xB1. All values SHALL be zero-extended to 32 bits.
REQ-015 paddr_i[1:0] SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, WAIT, PWR and RESP.
REQ-017 IDLE -> WAIT in the setup cycle (psel_i=1, penable_i=0); the address and direction SHALL be captured in this cycle.
REQ-018 WAIT SHALL count RD_WAIT cycles. It then goes to PWR if the access is a read of entry i with pd_on_i[i]=0; otherwise it goes to RESP.
REQ-019 In PWR, pwrreq_o[i] SHALL be 1. The block leaves PWR for RESP when pd_on_i[i]=1 (present=1) or after PWR_TIMEOUT cycles (present=0). A timeout SHALL NOT assert pslverr_o.
REQ-020 present SHALL equal pd_on_i[i] sampled on WAIT exit when PWR is skipped.
REQ-021 RESP SHALL drive pready_o=1 with prdata_o valid for exactly one cycle, then return to IDLE.
REQ-022 pwrreq_o SHALL drop in the RESP cycle.
REQ-023 Latency: with RD_WAIT=0 and no power wait, pready_o SHALL be 1 in the first access cycle.
REQ-024 Latency: in general, pready_o SHALL be 1 in access cycle 1+RD_WAIT, plus the PWR cycles when power-up is needed.
REQ-025 Writes SHALL complete with the same timing as reads, with pslverr_o=1 and prdata_o=0, and SHALL have no side effects.
REQ-026 Outside RESP, pready_o, pslverr_o and prdata_o SHALL all be 0.
REQ-027 If psel_i drops before RESP (protocol violation), the FSM SHALL return to IDLE on the next edge, clear pwrreq_o and drop the transfer silently.
REQ-028 Back-to-back transfers SHALL be accepted: a setup cycle that immediately follows RESP SHALL start a new transfer.
REQ-029 At most one pwrreq_o bit SHALL be 1 at any time.

Reset
REQ-030 While rst_i=1, the block SHALL have state=IDLE, pready_o=0, pslverr_o=0, prdata_o=0, pwrreq_o=0 and all counters at 0.
REQ-031 Reset asserted mid-transfer SHALL apply REQ-030 immediately, without waiting for a clock edge.
REQ-032 After reset is released, the first transfer SHALL begin at the next setup cycle.

Structure
REQ-033 Package debug_rom_pkg SHALL hold: FSM state enum, CID0..3 constants, ID register offsets, and the entry-format field constants (format bit, present bit).
REQ-034 The wait/timeout counter SHALL be 16 bits, shared between WAIT and PWR.
REQ-035 Sub-module debug_rom_id_regs SHALL hold the purely combinational offset-to-ID-value decode. All sequential logic stays in the top level.

Verification
REQ-036 RD_WAIT=1, entry_base[0]=20'h10010, pd_on_i=all 1, read 0x000 -> pready_o in access cycle 2, prdata_o=0x10010003, pslverr_o=0.
REQ-037 NUM_ENTRIES=7, read 0x01C and 0xE00 -> prdata_o=0, pslverr_o=0. Read 0xFF4 -> 0x10. Read 0xFE8 with REVISION=2 -> 0x28.
REQ-038 pd_on_i[3]=0, read 0x00C, raise pd_on_i[3] 5 cycles after pwrreq_o[3] rises -> present bit=1. pwrreq_o[3] is 0 after RESP.
REQ-039 PWR_TIMEOUT=16, pd_on_i[2] held 0, read 0x008 -> pready_o after exactly 16 PWR cycles, bit0=0, pslverr_o=0.
REQ-040 Write to 0x000 -> pslverr_o=1 with read timing. A subsequent read of 0x000 returns unchanged data.
REQ-041 Assert rst_i during PWR; separately, drop psel_i during WAIT -> both: pwrreq_o=0, FSM IDLE, no pready_o pulse. The next read completes normally.

Source files
------------

// File: rtl/debug_rom_pkg.sv
// Shared types and constants for the APB debug ROM table: FSM states,
// CoreSight ID register offsets/values and entry-format bit positions.
package debug_rom_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, PWR, RESP} state_e;

  localparam logic [7:0] CID0_VAL = 8'h0D;
  localparam logic [7:0] CID1_VAL = 8'h10;
  localparam logic [7:0] CID2_VAL = 8'h05;
  localparam logic [7:0] CID3_VAL = 8'hB1;

  localparam logic [11:0] OFF_PID4 = 12'hFD0;
  localparam logic [11:0] OFF_PID5 = 12'hFD4;
  localparam logic [11:0] OFF_PID6 = 12'hFD8;
  localparam logic [11:0] OFF_PID7 = 12'hFDC;
  localparam logic [11:0] OFF_PID0 = 12'hFE0;
  localparam logic [11:0] OFF_PID1 = 12'hFE4;
  localparam logic [11:0] OFF_PID2 = 12'hFE8;
  localparam logic [11:0] OFF_PID3 = 12'hFEC;
  localparam logic [11:0] OFF_CID0 = 12'hFF0;
  localparam logic [11:0] OFF_CID1 = 12'hFF4;
  localparam logic [11:0] OFF_CID2 = 12'hFF8;
  localparam logic [11:0] OFF_CID3 = 12'hFFC;

  localparam int ENTRY_FMT_BIT     = 1;
  localparam int ENTRY_PRESENT_BIT = 0;

endpackage

// File: rtl/debug_rom_id_regs.sv
// Combinational decode of a word-aligned table offset to its peripheral /
// component ID value; anything that is not an ID register reads as zero.
module debug_rom_id_regs
  import debug_rom_pkg::*;
#(
  parameter logic [11:0] PART_NUM    = 12'h004,
  parameter logic [6:0]  JEP106_ID   = 7'h00,
  parameter logic [3:0]  JEP106_CONT = 4'h0,
  parameter logic [3:0]  REVISION    = 4'h0
) (
  input  logic [11:0] off_i,
  output logic [31:0] val_o
);

  always_comb begin
    val_o = '0;
    case (off_i)
      OFF_PID4: val_o[7:0] = {4'h0, JEP106_CONT};
      OFF_PID0: val_o[7:0] = PART_NUM[7:0];
      OFF_PID1: val_o[7:0] = {JEP106_ID[3:0], PART_NUM[11:8]};
      OFF_PID2: val_o[7:0] = {REVISION, 1'b1, JEP106_ID[6:4]};
      OFF_CID0: val_o[7:0] = CID0_VAL;
      OFF_CID1: val_o[7:0] = CID1_VAL;
      OFF_CID2: val_o[7:0] = CID2_VAL;
      OFF_CID3: val_o[7:0] = CID3_VAL;
      default:  val_o = '0;
    endcase
  end

endmodule

// File: rtl/debug_rom_table_apb.sv
// APB slave serving a CoreSight-style ROM table; entry reads may first
// request power-up of the component's domain and report presence.
module debug_rom_table_apb
  import debug_rom_pkg::*;
#(
  parameter int          NUM_ENTRIES = 7,
  parameter int          RD_WAIT     = 1,
  parameter int          PWR_TIMEOUT = 256,
  parameter logic [11:0] PART_NUM    = 12'h004,
  parameter logic [6:0]  JEP106_ID   = 7'h00,
  parameter logic [3:0]  JEP106_CONT = 4'h0,
  parameter logic [3:0]  REVISION    = 4'h0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        psel_i,
  input  logic                        penable_i,
  input  logic                        pwrite_i,
  input  logic [11:0]                 paddr_i,
  output logic [31:0]                 prdata_o,
  output logic                        pready_o,
  output logic                        pslverr_o,
  input  logic [NUM_ENTRIES*20-1:0]   entry_base_i,
  input  logic [NUM_ENTRIES-1:0]      pd_on_i,
  output logic [NUM_ENTRIES-1:0]      pwrreq_o
);

  localparam int          IW        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [15:0] WAIT_LAST = 16'(RD_WAIT - 1);
  localparam logic [15:0] PWR_LAST  = 16'(PWR_TIMEOUT - 1);

  state_e                        state_q;
  logic [9:0]                    addr_q;
  logic                          wr_q;
  logic [15:0]                   cnt_q;
  logic [NUM_ENTRIES-1:0]        pwrreq_q;
  logic                          pready_q, pslverr_q;
  logic [31:0]                   prdata_q;

  logic [NUM_ENTRIES-1:0][19:0]  base_arr;
  logic [9:0]                    cur_word;
  logic                          cur_wr;
  logic [IW-1:0]                 ent;
  logic                          is_entry, ent_on, setup, exit_now, need_pwr;
  logic [31:0]                   id_val, entry_val, resp_data;
  logic                          unused_addr_lsb;

  assign base_arr        = entry_base_i;
  assign unused_addr_lsb = ^paddr_i[1:0];
  assign setup           = psel_i && !penable_i;

  // In IDLE the live bus address is used so a zero-wait read can decide
  // its next state on the setup edge; afterwards the captured copy is used.
  assign cur_word = (state_q == IDLE) ? paddr_i[11:2] : addr_q;
  assign cur_wr   = (state_q == IDLE) ? pwrite_i : wr_q;
  assign ent      = cur_word[IW-1:0];
  assign is_entry = cur_word < 10'(NUM_ENTRIES);
  assign ent_on   = is_entry && pd_on_i[ent];
  assign need_pwr = !cur_wr && is_entry && !ent_on;
  assign exit_now = (RD_WAIT == 0) ? (state_q == IDLE && setup)
                                   : (state_q == WAIT && psel_i && cnt_q == WAIT_LAST);

  debug_rom_id_regs #(
    .PART_NUM    (PART_NUM),
    .JEP106_ID   (JEP106_ID),
    .JEP106_CONT (JEP106_CONT),
    .REVISION    (REVISION)
  ) u_id_regs (
    .off_i ({cur_word, 2'b00}),
    .val_o (id_val)
  );

  always_comb begin
    entry_val                    = '0;
    entry_val[31:12]             = base_arr[ent];
    entry_val[ENTRY_FMT_BIT]     = 1'b1;
    entry_val[ENTRY_PRESENT_BIT] = ent_on;
    resp_data = cur_wr ? 32'h0 : (is_entry ? entry_val : id_val);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      pwrreq_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (setup) begin
          addr_q  <= paddr_i[11:2];
          wr_q    <= pwrite_i;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: if (!psel_i) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
        PWR: if (!psel_i) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          pwrreq_q <= '0;
        end else if (ent_on || cnt_q == PWR_LAST) begin
          // Timeout is not an error: the entry simply reads as not present.
          state_q   <= RESP;
          cnt_q     <= '0;
          pwrreq_q  <= '0;
          pready_q  <= 1'b1;
          pslverr_q <= 1'b0;
          prdata_q  <= resp_data;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
        RESP: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase

      if (exit_now) begin
        cnt_q <= '0;
        if (need_pwr) begin
          state_q  <= PWR;
          pwrreq_q <= NUM_ENTRIES'(1) << ent;
        end else begin
          state_q   <= RESP;
          pready_q  <= 1'b1;
          pslverr_q <= cur_wr;
          prdata_q  <= resp_data;
        end
      end
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign pwrreq_o  = pwrreq_q;

endmodule

// File: tb/tb_debug_rom_table_apb.sv
// Scoreboard bench: the driver queues hand-computed responses, a negedge
// monitor pops and compares whenever pready_o is seen.
module tb_debug_rom_table_apb;
  localparam int N = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0]   paddr = '0;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [N*20-1:0] entry_base;
  logic [N-1:0]  pd_on = 7'b1110011;
  logic [N-1:0]  pwrreq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  debug_rom_table_apb #(
    .NUM_ENTRIES (N),
    .RD_WAIT     (1),
    .PWR_TIMEOUT (16),
    .PART_NUM    (12'h4A5),
    .JEP106_ID   (7'h00),
    .JEP106_CONT (4'h3),
    .REVISION    (4'h2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .psel_i       (psel),
    .penable_i    (penable),
    .pwrite_i     (pwrite),
    .paddr_i      (paddr),
    .prdata_o     (prdata),
    .pready_o     (pready),
    .pslverr_o    (pslverr),
    .entry_base_i (entry_base),
    .pd_on_i      (pd_on),
    .pwrreq_o     (pwrreq)
  );

  always #5 clk = ~clk;

  // Monitor: counts access cycles and checks every response against the queue.
  int acc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (psel && penable) acc = acc + 1;
      else acc = 0;
      checks++;
      if ($countones(pwrreq) > 1) begin
        errors++;
        $display("FAIL pwrreq_onehot got=%b", pwrreq);
      end
      if (pready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pready data=%h err=%b", prdata, pslverr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (prdata !== e.data || pslverr !== e.err || acc != e.lat || pwrreq !== '0) begin
            errors++;
            $display("FAIL resp got data=%h err=%b lat=%0d pwrreq=%b exp data=%h err=%b lat=%0d pwrreq=0",
                     prdata, pslverr, acc, pwrreq, e.data, e.err, e.lat);
          end
        end
      end else begin
        checks++;
        if (prdata !== 32'h0 || pslverr !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs got data=%h err=%b exp 0/0", prdata, pslverr);
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the RESP cycle.
  task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] d,
                     input logic e, input int lat);
    exp_t x;
    bit   got;
    x.data = d; x.err = e; x.lat = lat;
    sb.push_back(x);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w;
    @(posedge clk); #1 penable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (pready) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h no pready within 100 cycles", a);
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wait_req(input int bitn, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (pwrreq[bitn]) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL pwrreq_rise bit=%0d got=0 exp=1", bitn);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < N; i++) entry_base[20*i +: 20] = 20'hA0000 + 20'(i);
    entry_base[19:0] = 20'h10010;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", {31'h0, pready}, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pwrreq", {25'h0, pwrreq}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Entries, end marker / reserved space and ID registers, back-to-back
    apb(12'h000, 1'b0, 32'h1001_0003, 1'b0, 2);
    apb(12'h004, 1'b0, 32'hA000_1003, 1'b0, 2);
    apb(12'h018, 1'b0, 32'hA000_6003, 1'b0, 2);
    apb(12'h01C, 1'b0, 32'h0000_0000, 1'b0, 2);
    apb(12'hE00, 1'b0, 32'h0000_0000, 1'b0, 2);
    apb(12'hFCC, 1'b0, 32'h0000_0000, 1'b0, 2);
    apb(12'hFF4, 1'b0, 32'h0000_0010, 1'b0, 2);
    apb(12'hFF3, 1'b0, 32'h0000_000D, 1'b0, 2);
    apb(12'hFF8, 1'b0, 32'h0000_0005, 1'b0, 2);
    apb(12'hFFC, 1'b0, 32'h0000_00B1, 1'b0, 2);
    apb(12'hFE8, 1'b0, 32'h0000_0028, 1'b0, 2);
    apb(12'hFE0, 1'b0, 32'h0000_00A5, 1'b0, 2);
    apb(12'hFE4, 1'b0, 32'h0000_0004, 1'b0, 2);
    apb(12'hFD0, 1'b0, 32'h0000_0003, 1'b0, 2);
    apb(12'hFD4, 1'b0, 32'h0000_0000, 1'b0, 2);
    apb(12'hFEC, 1'b0, 32'h0000_0000, 1'b0, 2);

    // Writes error out with read timing and change nothing
    apb(12'h000, 1'b1, 32'h0000_0000, 1'b1, 2);
    apb(12'hFF0, 1'b1, 32'h0000_0000, 1'b1, 2);
    apb(12'h008, 1'b1, 32'h0000_0000, 1'b1, 2);
    apb(12'h000, 1'b0, 32'h1001_0003, 1'b0, 2);
    chk("write_no_pwrreq", {25'h0, pwrreq}, 32'h0);

    // Power-up: domain 3 comes up 5 cycles after the request
    fork
      apb(12'h00C, 1'b0, 32'hA000_3003, 1'b0, 8);
      begin
        wait_req(3, seen);
        repeat (5) @(posedge clk);
        #1 pd_on[3] = 1'b1;
      end
    join
    chk("pwrreq3_after", {25'h0, pwrreq}, 32'h0);

    // Power-up timeout: 1 WAIT + 16 PWR cycles, present=0, no error
    apb(12'h008, 1'b0, 32'hA000_2002, 1'b0, 18);

    // Reset asserted while waiting for power
    psel = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    wait_req(2, seen);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_pwrreq", {25'h0, pwrreq}, 32'h0);
    chk("rst_mid_pready", {31'h0, pready}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // psel dropped during WAIT: transfer vanishes, no pready
    psel = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b0;
    @(posedge clk); #1 penable = 1'b1; psel = 1'b0;
    #1 penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pwrreq", {25'h0, pwrreq}, 32'h0);

    // Normal traffic afterwards
    apb(12'h000, 1'b0, 32'h1001_0003, 1'b0, 2);
    apb(12'hFF4, 1'b0, 32'h0000_0010, 1'b0, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
